// File: rtl/ysyx_22050612_alu_arb.sv
// ysyx_22050612_alu_arb
//   Two-port round-robin arbiter/sequencer for the shared 64-bit ALU.
//   One operation in flight at a time: IDLE (accept) -> EXEC (ALU settles on
//   registered operands) -> RESP (hold result until owner takes it).
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   reqN_valid/ready            operation handshake for requester N (0/1)
//   reqN_mode/a/b               ALU mode (8b) and operands (64b)
//   rspN_valid/ready            result handshake for requester N
//   rsp_data, rsp_err           shared result bus and illegal-mode flag
//   alu_mode, alu_a, alu_b      registered drive to the shared ALU
//   alu_z                       combinational ALU result
//
// Configuration
//   YSYX_22050612_ALU_ARB_MODE_CHECK_EN: when defined, illegal modes bypass
//   the ALU and answer with rsp_data=0, rsp_err=1 one cycle after accept.
//   When undefined, every mode is forwarded and rsp_err is always 0.
module ysyx_22050612_alu_arb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [7:0]  req0_mode,
  input  logic [7:0]  req1_mode,
  input  logic [63:0] req0_a,
  input  logic [63:0] req1_a,
  input  logic [63:0] req0_b,
  input  logic [63:0] req1_b,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready,
  output logic [63:0] rsp_data,
  output logic        rsp_err,
  output logic [7:0]  alu_mode,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  input  logic [63:0] alu_z
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        prio_q, prio_d;
  logic        owner_q, owner_d;
  logic [7:0]  alu_mode_q, alu_mode_d;
  logic [63:0] alu_a_q, alu_a_d;
  logic [63:0] alu_b_q, alu_b_d;
  logic [63:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;

  logic        grant0, grant1;
  logic        accept;
  logic [7:0]  sel_mode;
  logic [63:0] sel_a, sel_b;
  logic        mode_ok;

  // prio only breaks ties; a lone requester is always granted.
  assign grant0 = req0_valid & (~req1_valid | ~prio_q);
  assign grant1 = req1_valid & (~req0_valid | prio_q);

  // rst_n is folded in so ready drops the instant reset asserts.
  assign req0_ready = (state_q == S_IDLE) & grant0 & rst_n;
  assign req1_ready = (state_q == S_IDLE) & grant1 & rst_n;
  assign accept     = req0_ready | req1_ready;

  assign sel_mode = grant1 ? req1_mode : req0_mode;
  assign sel_a    = grant1 ? req1_a    : req0_a;
  assign sel_b    = grant1 ? req1_b    : req0_b;

  always_comb begin
`ifdef YSYX_22050612_ALU_ARB_MODE_CHECK_EN
    case (sel_mode)
      8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8, 8'd10: mode_ok = 1'b1;
      default:                                              mode_ok = 1'b0;
    endcase
`else
    mode_ok = 1'b1;
`endif
  end

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    owner_d    = owner_q;
    alu_mode_d = alu_mode_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          owner_d = req1_ready;
          prio_d  = ~req1_ready;
          if (mode_ok) begin
            alu_mode_d = sel_mode;
            alu_a_d    = sel_a;
            alu_b_d    = sel_b;
            rsp_err_d  = 1'b0;
            state_d    = S_EXEC;
          end else begin
            // Illegal mode: ALU drive left untouched, answer immediately.
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            state_d    = S_RESP;
          end
        end
      end
      S_EXEC: begin
        rsp_data_d = alu_z;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (owner_q ? rsp1_ready : rsp0_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      prio_q     <= 1'b0;
      owner_q    <= 1'b0;
      alu_mode_q <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      owner_q    <= owner_d;
      alu_mode_q <= alu_mode_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign rsp0_valid = (state_q == S_RESP) & ~owner_q;
  assign rsp1_valid = (state_q == S_RESP) &  owner_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign alu_mode   = alu_mode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;

endmodule

// File: tb/tb_ysyx_22050612_alu_arb.sv
module tb_ysyx_22050612_alu_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [7:0]  req0_mode = '0, req1_mode = '0;
  logic [63:0] req0_a = '0, req1_a = '0, req0_b = '0, req1_b = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [63:0] rsp_data;
  logic        rsp_err;
  logic [7:0]  alu_mode;
  logic [63:0] alu_a, alu_b, alu_z;

  always #5 clk = ~clk;

  ysyx_22050612_alu_arb dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_mode(req0_mode), .req1_mode(req1_mode),
    .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_mode(alu_mode), .alu_a(alu_a), .alu_b(alu_b), .alu_z(alu_z)
  );

  // Reference ALU; unknown modes produce a recognisable non-zero value.
  function automatic logic [63:0] ref_alu(input logic [7:0] m, input logic [63:0] a, input logic [63:0] b);
    case (m)
      8'd0:    return a + b;
      8'd1:    return a - b;
      8'd2:    return {63'd0, ($signed(a) < $signed(b))};
      8'd3:    return {63'd0, (a < b)};
      8'd4:    return a | b;
      8'd6:    return a & b;
      8'd7:    return a ^ b;
      8'd8:    return a << b[5:0];
      8'd10:   return $unsigned($signed(a) >>> b[5:0]);
      default: return a + b + 64'd1;
    endcase
  endfunction

  function automatic logic is_legal(input logic [7:0] m);
    return (m inside {8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8, 8'd10});
  endfunction

  assign alu_z = ref_alu(alu_mode, alu_a, alu_b);

  typedef struct {
    logic        port;
    logic [63:0] data;
    logic        err;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t        sb[$];
  logic        grants[$];
  logic [63:0] rsp_log[$];
  logic        last_err;
  int          n_vec = 0, n_err = 0;
  int          cyc = 0;
  logic        prev_rv = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t make_exp(input logic p, input logic [7:0] m, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    e.port = p;
    e.acc_cyc = cyc;
`ifdef YSYX_22050612_ALU_ARB_MODE_CHECK_EN
    if (!is_legal(m)) begin
      e.data = '0; e.err = 1'b1; e.lat = 1;
    end else begin
      e.data = ref_alu(m, a, b); e.err = 1'b0; e.lat = 2;
    end
`else
    e.data = ref_alu(m, a, b); e.err = 1'b0; e.lat = 2;
`endif
    return e;
  endfunction

  // Monitor: push on accept, check owner/latency on response rise, pop on take.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rv = 1'b0;
    end else begin
      logic a0, a1;
      a0 = req0_valid & req0_ready;
      a1 = req1_valid & req1_ready;
      if (a0 | a1) chk("single_grant", {62'd0, a1, a0} == 64'd3, 64'd0);
      if (a0) begin sb.push_back(make_exp(1'b0, req0_mode, req0_a, req0_b)); grants.push_back(1'b0); end
      else if (a1) begin sb.push_back(make_exp(1'b1, req1_mode, req1_a, req1_b)); grants.push_back(1'b1); end
      if ((rsp0_valid | rsp1_valid) && !prev_rv) begin
        if (sb.size() == 0) chk("spurious_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
        else begin
          chk("rsp_owner", {rsp1_valid, rsp0_valid}, sb[0].port ? 2'b10 : 2'b01);
          chk("rsp_latency", cyc - sb[0].acc_cyc, sb[0].lat);
        end
      end
      if (((rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready)) && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_err", rsp_err, e.err);
        rsp_log.push_back(rsp_data);
        last_err = rsp_err;
      end
      prev_rv = rsp0_valid | rsp1_valid;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {req1_ready, req0_ready}, 2'b00);
    chk({tag, "_rsp_valid"}, {rsp1_valid, rsp0_valid}, 2'b00);
    chk({tag, "_rsp_data"}, rsp_data, 64'd0);
    chk({tag, "_rsp_err"}, rsp_err, 1'b0);
    chk({tag, "_alu_mode"}, alu_mode, 8'd0);
    chk({tag, "_alu_a"}, alu_a, 64'd0);
    chk({tag, "_alu_b"}, alu_b, 64'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic p, input logic [7:0] m, input logic [63:0] a, input logic [63:0] b);
    logic got = 1'b0;
    if (p) begin req1_mode = m; req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else   begin req0_mode = m; req0_a = a; req0_b = b; req0_valid = 1'b1; end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (p ? req1_ready : req0_ready) begin got = 1'b1; break; end
    end
    chk("accept_seen", got, 1'b1);
    @(posedge clk);
    #1;
    if (p) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_drain();
    logic ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      if (sb.size() == 0 && !rsp0_valid && !rsp1_valid) begin ok = 1'b1; break; end
    end
    chk("drain", ok, 1'b1);
    #1;
  endtask

  initial begin
    logic [7:0] legal_modes [9];
    logic       seen;
    legal_modes = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8, 8'd10};

    // Reset state, with requests already asserted.
    req0_valid = 1'b1; req1_valid = 1'b1;
    #12;
    check_reset_outputs("reset");
    req0_valid = 1'b0; req1_valid = 1'b0;
    release_reset();

    // Single op on port 0, then subtract on port 1.
    drive_op(1'b0, 8'd0, 64'd5, 64'd7);
    wait_drain();
    chk("add_5_7", rsp_log[$], 64'd12);
    drive_op(1'b1, 8'd1, 64'd3, 64'd5);
    wait_drain();
    chk("sub_3_5", rsp_log[$], 64'hFFFF_FFFF_FFFF_FFFE);

    // Contention from reset: grants must alternate starting at port 0.
    rst_n = 1'b0;
    #2;
    release_reset();
    grants.delete(); rsp_log.delete();
    req0_mode = 8'd7; req0_a = 64'hF0; req0_b = 64'hFF; req0_valid = 1'b1;
    req1_mode = 8'd6; req1_a = 64'hF0; req1_b = 64'h3C; req1_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      if (grants.size() >= 4) break;
    end
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_drain();
    chk("contention_count", grants.size(), 4);
    if (grants.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("contention_grant", grants[i], i[0]);
        chk("contention_data", rsp_log[i], i[0] ? 64'h30 : 64'h0F);
      end
    end

    // Backpressure: owner holds off, non-owner ready ignored, no new accepts.
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    drive_op(1'b0, 8'd8, 64'd1, 64'd4);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp0_valid) begin seen = 1'b1; break; end
    end
    chk("bp_rsp_seen", seen, 1'b1);
    @(posedge clk);
    #1;
    req0_mode = 8'd0; req0_a = 64'd1; req0_b = 64'd1; req0_valid = 1'b1;
    req1_mode = 8'd0; req1_a = 64'd2; req1_b = 64'd2; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp0_valid", rsp0_valid, 1'b1);
      chk("bp_rsp1_valid", rsp1_valid, 1'b0);
      chk("bp_rsp_data", rsp_data, 64'd16);
      chk("bp_alu", {alu_mode, alu_a[7:0], alu_b[7:0]}, {8'd8, 8'd1, 8'd4});
      chk("bp_req_ready", {req1_ready, req0_ready}, 2'b00);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    wait_drain();

    // Reset during EXEC: outputs clear at once, in-flight op is dropped.
    drive_op(1'b0, 8'd0, 64'd100, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midop");
    sb.delete();
    @(posedge clk);
    release_reset();
    drive_op(1'b0, 8'd0, 64'd9, 64'd9);
    wait_drain();
    chk("post_reset_add", rsp_log[$], 64'd18);

    // Illegal mode 5.
    drive_op(1'b0, 8'd5, 64'd1, 64'd2);
    wait_drain();
`ifdef YSYX_22050612_ALU_ARB_MODE_CHECK_EN
    chk("illegal_data", rsp_log[$], 64'd0);
    chk("illegal_err", last_err, 1'b1);
`else
    chk("illegal_data", rsp_log[$], 64'd4);
    chk("illegal_err", last_err, 1'b0);
`endif

    // Random legal traffic on both ports.
    for (int i = 0; i < 12; i++) begin
      drive_op(1'($urandom_range(0, 1)), legal_modes[$urandom_range(0, 8)],
               {$urandom, $urandom}, {$urandom, $urandom});
    end
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_22050612_alu_arb.md
# ysyx_22050612_alu_arb

Two-port arbiter and sequencer for the shared 64-bit integer ALU. It accepts operation requests (mode, A, B) from two requesters over valid/ready handshakes and grants one at a time with round-robin priority. It drives the shared ALU's operand/mode inputs from registers, captures the ALU result and returns it to the requester that issued the operation. It sits between the execute-stage requesters (e.g. integer pipe and address/branch unit) and the single ALU instance.

## Interface
Parameters:
- none; widths fixed: mode 8 bits, data 64 bits.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req0_valid`, `req1_valid`  in  1  requester i has an operation.
- `req0_ready`, `req1_ready`  out  1  requester i's operation accepted this cycle.
- `req0_mode`, `req1_mode`  in  8  ALU mode code.
- `req0_a`, `req1_a`, `req0_b`, `req1_b`  in  64  operands.
- `rsp0_valid`, `rsp1_valid`  out  1  result for requester i available.
- `rsp0_ready`, `rsp1_ready`  in  1  requester i takes its result.
- `rsp_data`  out  64  result, shared by both response ports.
- `rsp_err`  out  1  illegal mode flag (see Configuration).
- `alu_mode`  out  8, `alu_a`  out  64, `alu_b`  out  64  registered drive to shared ALU.
- `alu_z`  in  64  combinational ALU result.

## Operation
- States: IDLE, EXEC, RESP. Reset state IDLE.
- Grant in IDLE: only one valid -> that port; both valid -> port selected by `prio` (1-bit, reset 0); none -> stay IDLE.
- `reqi_ready` = (state==IDLE) & grant_i & rst_n; combinational from valid (ready may depend on valid; requesters must not make valid depend on ready).
- Accept (valid&ready) in IDLE: latch mode/A/B into `alu_*`, record owner, set `prio` = other port, go to EXEC.
- EXEC: one cycle; `alu_z` captured into `rsp_data`; go to RESP.
- RESP: `rsp<owner>_valid`=1, other rsp_valid=0; hold `rsp_data`, `rsp_err`, `alu_*` stable until `rsp<owner>_ready`=1, then IDLE. Ready from the non-owner port is ignored.
- Legal modes: 0 add, 1 sub, 2 slt, 3 sltu, 4 or, 6 and, 7 xor, 8 sll, 10 sra.
- No new acceptance in EXEC or RESP; at most one operation in flight.

## Timing
- Reset values: `reqi_ready`=0, `rspi_valid`=0, `rsp_data`=0, `rsp_err`=0, `alu_mode`=0, `alu_a`=0, `alu_b`=0, state IDLE, owner 0, `prio`=0.
- Accept at edge N -> `alu_*` valid in cycle N+1 (EXEC) -> `rsp_valid` high from cycle N+2.
- Latency 2 cycles accept-to-response; minimum 3 cycles per operation (accept cycle, EXEC, RESP with ready=1 same cycle).
- Result taken in cycle M (RESP, ready=1) -> IDLE in M+1; new accept possible in M+1.
- Both valid continuously: grants alternate 0,1,0,1... from reset.
- `rst_n` low at any point: immediate return to IDLE with reset values; in-flight operation dropped, no response issued.

## Configuration
- `YSYX_22050612_ALU_ARB_MODE_CHECK_EN` defined: on accept of an illegal mode, skip EXEC, go directly to RESP with `rsp_data`=0, `rsp_err`=1 (response 1 cycle after accept); `alu_*` not updated. Legal modes give `rsp_err`=0.
- Not defined: every mode forwarded to the ALU unchanged; `rsp_err` tied 0; ALU output returned as-is.

## Test plan
- Single op: port 0, mode 0, A=5, B=7 -> `req0_ready` 1 in accept cycle, `rsp0_valid` 2 cycles later with `rsp_data`=12, `rsp1_valid` stays 0.
- Subtract on port 1: mode 1, A=3, B=5 -> `rsp1_valid`, `rsp_data`=0xFFFF_FFFF_FFFF_FFFE.
- Contention: both valid from reset with ops (mode 7, A=0xF0, B=0xFF) and (mode 6, A=0xF0, B=0x3C) -> port 0 served first (0x0F), then port 1 (0x30), then 0 again; neither port starved.
- Backpressure: hold `rsp0_ready`=0 for 5 cycles in RESP -> `rsp0_valid`, `rsp_data`, `alu_*` stable, both `reqi_ready`=0; `rsp1_ready`=1 has no effect.
- Reset mid-op: drop `rst_n` in EXEC -> all outputs reset values immediately; after release, first accepted op from port 0 completes normally, no stale response.
- Illegal mode 5 with macro defined -> `rsp_valid` 1 cycle after accept, `rsp_data`=0, `rsp_err`=1; without macro -> 2-cycle latency, `rsp_err`=0.
